// File: rtl/conv_window_scanner.sv
// Raster-scan window-centre address generator for the 3x3 padding select stage.
// Optional macro STRIDE2_EN enables the stride-2 walk; without it i_stride2 is ignored.
module conv_window_scanner #(
  parameter int HALF_W = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_stride2,
  input  logic                  i_ready,
  output logic [2*HALF_W-1:0]   o_localAddr,
  output logic                  o_valid,
  output logic                  o_first,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [HALF_W-1:0] row;
  logic [HALF_W-1:0] col;
  logic [HALF_W-1:0] step;
  logic [HALF_W-1:0] coord_max;
  logic [HALF_W-1:0] next_row;
  logic [HALF_W-1:0] next_col;

`ifdef STRIDE2_EN
  logic stride2_q;

  // Stride-2 stops one short of the edge so every centre lands on an even coordinate.
  assign step      = stride2_q ? HALF_W'(2) : HALF_W'(1);
  assign coord_max = stride2_q ? {{(HALF_W-1){1'b1}}, 1'b0} : {HALF_W{1'b1}};
`else
  logic unused_stride2;

  assign unused_stride2 = i_stride2;
  assign step           = HALF_W'(1);
  assign coord_max      = {HALF_W{1'b1}};
`endif

  // The address is simply the registered coordinate pair.
  assign o_localAddr = {row, col};

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    next_row = row;
    next_col = col + step;
    if (col == coord_max) begin
      next_col = '0;
      next_row = row + step;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      o_valid   <= 1'b0;
      o_first   <= 1'b0;
      o_last    <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
`ifdef STRIDE2_EN
      stride2_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          if (i_start) begin
            state   <= SCAN;
            row     <= '0;
            col     <= '0;
            o_valid <= 1'b1;
            o_first <= 1'b1;
            o_last  <= 1'b0;
            o_busy  <= 1'b1;
`ifdef STRIDE2_EN
            stride2_q <= i_stride2;
`endif
          end
        end

        SCAN: begin
          if (i_ready) begin
            if (o_last) begin
              // Coordinates are cleared so the idle address reads as zero.
              state   <= DONE;
              row     <= '0;
              col     <= '0;
              o_valid <= 1'b0;
              o_first <= 1'b0;
              o_last  <= 1'b0;
              o_done  <= 1'b1;
            end else begin
              row     <= next_row;
              col     <= next_col;
              o_first <= 1'b0;
              o_last  <= (next_row == coord_max) && (next_col == coord_max);
            end
          end
        end

        DONE: begin
          state  <= IDLE;
          o_done <= 1'b0;
          o_busy <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
          o_first <= 1'b0;
          o_last  <= 1'b0;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
